// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared core definitions: core FSM state encodings, NOP word, reset PC default
package fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WRITE  = 3'd4
  } core_state_e;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response handshake bundle
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: owns the PC and fetches one instruction per FETCH visit
// Optional macro FETCH_TIMEOUT_EN adds a request timeout that raises the sticky fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [2:0]      state,
  input  logic            pc_we,
  input  logic [XLEN-1:0] pc_wdata,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] instr_raw,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc,
  output logic            fetch_done,
  output logic            fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] instr_raw_q, instr_raw_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_done_q, fetch_done_d;
  logic            fault_q, fault_d;
  logic            handshake;
  logic            in_fetch;
  logic            timed_out;

  assign handshake = imem_req_q && imem.imem_ready;
  assign in_fetch  = (state == FETCH);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Held at zero outside REQ so every entry to REQ starts a fresh count.
  always_comb begin
    tmo_cnt_d = '0;
    if (fsm_q == REQ && !handshake) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  assign timed_out = (fsm_q == REQ) && !handshake &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timed_out             = 1'b0;
`endif

  always_comb begin
    fsm_d        = fsm_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    instr_raw_d  = instr_raw_q;
    instr_pc_d   = instr_pc_q;
    pc_d         = pc_q;
    fetch_done_d = 1'b0;
    fault_d      = fault_q;

    case (fsm_q)
      IDLE: begin
        if (in_fetch && !fault_q) begin
          if (pc_q[1:0] == 2'b00) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
            fsm_d       = REQ;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      REQ: begin
        // The state input is ignored here: a started transfer always completes.
        if (handshake) begin
          instr_raw_d  = imem.imem_rdata;
          instr_pc_d   = imem_addr_q;
          fetch_done_d = 1'b1;
          imem_req_d   = 1'b0;
          pc_d         = imem_addr_q + 32'd4;
          fsm_d        = DONE;
        end else if (timed_out) begin
          fault_d    = 1'b1;
          imem_req_d = 1'b0;
          fsm_d      = DONE;
        end
      end
      DONE: begin
        if (!in_fetch) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d      = IDLE;
        imem_req_d = 1'b0;
      end
    endcase

    if (pc_we) begin
      pc_d = pc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm_q        <= IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      instr_raw_q  <= NOP_INSTR;
      instr_pc_q   <= '0;
      pc_q         <= RESET_PC;
      fetch_done_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      instr_raw_q  <= instr_raw_d;
      instr_pc_q   <= instr_pc_d;
      pc_q         <= pc_d;
      fetch_done_q <= fetch_done_d;
      fault_q      <= fault_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;
  assign instr_raw      = instr_raw_q;
  assign instr_pc       = instr_pc_q;
  assign pc             = pc_q;
  assign fetch_done     = fetch_done_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  state;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic [31:0] instr_raw;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        fetch_done;
  logic        fault;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .state      (state),
    .pc_we      (pc_we),
    .pc_wdata   (pc_wdata),
    .imem       (imem),
    .instr_raw  (instr_raw),
    .instr_pc   (instr_pc),
    .pc         (pc),
    .fetch_done (fetch_done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: what a completed fetch must leave behind.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_0000;
    m_instr = NOP_INSTR;
    m_ipc   = 32'h0;
    m_fault = 1'b0;
  endtask

  task automatic check_arch(input string tag);
    check({tag, ".pc"},        pc,        m_pc);
    check({tag, ".instr_raw"}, instr_raw, m_instr);
    check({tag, ".instr_pc"},  instr_pc,  m_ipc);
    check({tag, ".fault"},     {31'b0, fault}, {31'b0, m_fault});
  endtask

  task automatic write_pc(input logic [31:0] v);
    pc_we    = 1'b1;
    pc_wdata = v;
    tick();
    pc_we = 1'b0;
    m_pc  = v;
    check("pc_write", pc, m_pc);
  endtask

  // One complete FETCH visit: request, optional wait states, handshake, settle back to idle.
  task automatic do_fetch(input int delay, input logic [31:0] data,
                          input bit hs_we, input logic [31:0] hs_pc,
                          input bit mid_we, input logic [31:0] mid_pc,
                          input bit leave);
    logic [31:0] req_addr;
    req_addr = m_pc;
    state = FETCH;
    imem.imem_ready = (delay == 0);
    imem.imem_rdata = data;
    tick();
    check("req_issued", {31'b0, imem.imem_req}, 32'd1);
    check("req_addr",   imem.imem_addr, req_addr);
    check("no_early_done", {31'b0, fetch_done}, 32'd0);
    if (leave) state = DECODE;
    for (int i = 0; i < delay; i++) begin
      if (i == 0 && mid_we) begin
        pc_we    = 1'b1;
        pc_wdata = mid_pc;
      end
      tick();
      pc_we = 1'b0;
      if (i == 0 && mid_we) check("mid_pc_write", pc, mid_pc);
      check("wait_req",  {31'b0, imem.imem_req}, 32'd1);
      check("wait_addr", imem.imem_addr, req_addr);
      check("wait_done", {31'b0, fetch_done}, 32'd0);
      check("wait_instr", instr_raw, m_instr);
    end
    imem.imem_ready = 1'b1;
    if (hs_we) begin
      pc_we    = 1'b1;
      pc_wdata = hs_pc;
    end
    tick();
    pc_we   = 1'b0;
    m_instr = data;
    m_ipc   = req_addr;
    m_pc    = hs_we ? hs_pc : req_addr + 32'd4;
    check("hs_done", {31'b0, fetch_done}, 32'd1);
    check("hs_req_drop", {31'b0, imem.imem_req}, 32'd0);
    check_arch("hs");
    imem.imem_ready = 1'($urandom_range(0, 1));
    imem.imem_rdata = $urandom;
    tick();
    check("done_pulse_end", {31'b0, fetch_done}, 32'd0);
    check("no_refetch", {31'b0, imem.imem_req}, 32'd0);
    if (!leave) begin
      tick();
      check("no_refetch2", {31'b0, imem.imem_req}, 32'd0);
      state = DECODE;
    end
    tick();
    tick();
    check_arch("post");
  endtask

  initial begin
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    rstn            = 1'b0;
    state           = DECODE;
    pc_we           = 1'b0;
    pc_wdata        = 32'h0;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;
    model_reset();
    tick();
    tick();
    check("rst_req",  {31'b0, imem.imem_req}, 32'd0);
    check("rst_addr", imem.imem_addr, 32'd0);
    check("rst_done", {31'b0, fetch_done}, 32'd0);
    check_arch("rst");
    rstn = 1'b1;
    tick();

    do_fetch(0, 32'h0050_0093, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_fetch(5, 32'h0010_8113, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_fetch(0, 32'h0000_006F, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0);

    write_pc(32'hFFFF_FFFC);
    do_fetch(1, 32'h1234_5013, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      r1 = $urandom; r1[1:0] = 2'b00;
      r2 = $urandom; r2[1:0] = 2'b00;
      r3 = $urandom; r3[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) write_pc(r1);
      begin
        int d;
        d = int'($urandom_range(0, 4));
        do_fetch(d, $urandom, ($urandom_range(0, 3) == 0), r2,
                 (d > 0) && ($urandom_range(0, 2) == 0), r3,
                 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the middle of an outstanding request.
    state = FETCH;
    imem.imem_ready = 1'b0;
    tick();
    check("rst_mid_req", {31'b0, imem.imem_req}, 32'd1);
    rstn = 1'b0;
    tick();
    model_reset();
    check("rst_mid_req_drop", {31'b0, imem.imem_req}, 32'd0);
    check_arch("rst_mid");
    rstn  = 1'b1;
    state = DECODE;
    tick();

    // Misaligned PC faults at fetch start and stays faulted.
    write_pc(32'h0000_0102);
    state = FETCH;
    imem.imem_ready = 1'b1;
    tick();
    m_fault = 1'b1;
    check("mis_fault", {31'b0, fault}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis_no_req",  {31'b0, imem.imem_req}, 32'd0);
      check("mis_no_done", {31'b0, fetch_done}, 32'd0);
    end
    state = DECODE;
    tick();
    write_pc(32'h0000_0200);
    state = FETCH;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sticky_no_req", {31'b0, imem.imem_req}, 32'd0);
    end
    check_arch("sticky");
    state = DECODE;
    rstn  = 1'b0;
    tick();
    rstn = 1'b1;
    model_reset();
    check_arch("fault_clear");
    tick();
    do_fetch(2, 32'h0042_0213, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    state = FETCH;
    imem.imem_ready = 1'b0;
    tick();
    check("tmo_req", {31'b0, imem.imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo_wait_req",   {31'b0, imem.imem_req}, 32'd1);
      check("tmo_wait_fault", {31'b0, fault}, 32'd0);
    end
    tick();
    m_fault = 1'b1;
    check("tmo_req_drop", {31'b0, imem.imem_req}, 32'd0);
    check("tmo_no_done",  {31'b0, fetch_done}, 32'd0);
    check_arch("tmo");
    state = DECODE;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
